// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared types and constants for the tensor MAC engine
package tensor_pkg;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DONE} state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/tensor_byte_serializer.sv
// rtl/tensor_byte_serializer.sv - emits the flattened accumulator one byte per read event
module tensor_byte_serializer
  import tensor_pkg::*;
#(
  parameter int NBYTES = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     emit,
  input  logic                     restart,
  input  logic [NBYTES*BYTE_W-1:0] data,
  output logic [BYTE_W-1:0]        data_out,
  output logic                     out_valid,
  output logic                     last
);
  localparam int PW = $clog2(NBYTES);

  logic [PW-1:0] ptr;

  assign last = emit && (ptr == PW'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        ptr <= '0;
      end else if (emit) begin
        data_out  <= data[ptr*BYTE_W +: BYTE_W];
        out_valid <= 1'b1;
        ptr       <= last ? '0 : ptr + 1'b1;
      end else if (restart) begin
        ptr <= '0;
      end
    end
  end
endmodule

// File: rtl/tensor_mmu_stream.sv
// rtl/tensor_mmu_stream.sv - byte-streamed N x N signed matrix multiply-accumulate engine
module tensor_mmu_stream
  import tensor_pkg::*;
#(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              acc_mode,
  input  logic              clear,
  output logic [BYTE_W-1:0] data_out,
  output logic              out_valid,
  output logic              result_ready,
  output logic              busy
);
  localparam int NN         = N * N;
  localparam int EB         = DW / BYTE_W;
  localparam int LOAD_BYTES = NN * EB;
  localparam int RES_BYTES  = NN * ACCW / BYTE_W;
  localparam int IW         = $clog2(N);
  localparam int EW         = $clog2(NN);
  localparam int LW         = $clog2(LOAD_BYTES);

  state_t state, next_state;

  logic                   wr_prev, rd_prev, wr_edge, rd_edge;
  logic                   mode, capture, abandon, emit, ser_last;
  logic [LW-1:0]          load_cnt;
  logic                   load_last;
  logic [IW-1:0]          i, j, k;
  logic                   k_last, j_last, i_last;
  logic signed [DW-1:0]   a_mem [NN];
  logic signed [DW-1:0]   b_mem [NN];
  logic signed [ACCW-1:0] acc   [NN];
  logic [ACCW-1:0]        psum, prod, sum;
  logic [DW-1:0]          a_el, b_el;
  logic [EW-1:0]          a_idx, b_idx, c_idx, w_idx;
  logic [NN*ACCW-1:0]     acc_flat;

  assign wr_edge   = wr_en & ~wr_prev;
  assign rd_edge   = rd_en & ~rd_prev;
  assign load_last = (load_cnt == LW'(LOAD_BYTES - 1));
  // A write edge in DONE restarts loading, so it is captured as an A byte.
  assign capture   = wr_edge && (state != COMPUTE);
  assign abandon   = wr_edge && (state == DONE);
  assign emit      = rd_edge && (state == DONE) && !wr_edge && !clear;
  assign w_idx     = EW'(load_cnt / EB);

  assign k_last = (k == IW'(N - 1));
  assign j_last = (j == IW'(N - 1));
  assign i_last = (i == IW'(N - 1));
  assign a_idx  = EW'(i * N + k);
  assign b_idx  = EW'(k * N + j);
  assign c_idx  = EW'(i * N + j);
  assign a_el   = a_mem[a_idx];
  assign b_el   = b_mem[b_idx];
  assign prod   = {{(ACCW-DW){a_el[DW-1]}}, a_el} * {{(ACCW-DW){b_el[DW-1]}}, b_el};
  assign sum    = psum + prod;

  for (genvar g = 0; g < NN; g++) begin : g_flat
    assign acc_flat[g*ACCW +: ACCW] = acc[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = LOAD_A;
    end else begin
      case (state)
        LOAD_A:  if (wr_edge && load_last) next_state = LOAD_B;
        LOAD_B:  if (wr_edge && load_last) next_state = COMPUTE;
        COMPUTE: if (k_last && j_last && i_last) next_state = DONE;
        DONE:    if (wr_edge || ser_last) next_state = LOAD_A;
        default: next_state = LOAD_A;
      endcase
    end
  end

  always_comb begin
    busy         = (state == COMPUTE);
    result_ready = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev  <= 1'b0;
      rd_prev  <= 1'b0;
      mode     <= 1'b0;
      load_cnt <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      psum     <= '0;
      for (int e = 0; e < NN; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        acc[e]   <= '0;
      end
    end else begin
      wr_prev <= wr_en;
      rd_prev <= rd_en;
      if (clear) begin
        load_cnt <= '0;
        i        <= '0;
        j        <= '0;
        k        <= '0;
        psum     <= '0;
        for (int e = 0; e < NN; e++) acc[e] <= '0;
      end else begin
        if (capture) begin
          if (state == LOAD_B) b_mem[w_idx][BYTE_W*(load_cnt % EB) +: BYTE_W] <= data_in;
          else                 a_mem[w_idx][BYTE_W*(load_cnt % EB) +: BYTE_W] <= data_in;
          load_cnt <= load_last ? '0 : load_cnt + 1'b1;
        end
        if (capture && (state == LOAD_B) && load_last) begin
          mode <= acc_mode;
          i    <= '0;
          j    <= '0;
          k    <= '0;
          psum <= '0;
        end
        if (state == COMPUTE) begin
          if (k_last) begin
            acc[c_idx] <= (mode ? acc[c_idx] : '0) + sum;
            psum       <= '0;
            k          <= '0;
            j          <= j_last ? '0 : j + 1'b1;
            if (j_last) i <= i_last ? '0 : i + 1'b1;
          end else begin
            psum <= sum;
            k    <= k + 1'b1;
          end
        end
      end
    end
  end

  tensor_byte_serializer #(.NBYTES(RES_BYTES)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .emit      (emit),
    .restart   (abandon),
    .data      (acc_flat),
    .data_out  (data_out),
    .out_valid (out_valid),
    .last      (ser_last)
  );
endmodule

// File: tb/tb_tensor_mmu_stream.sv
// tb/tb_tensor_mmu_stream.sv - scoreboard bench for the tensor MAC engine
module tb_tensor_mmu_stream;
  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int ACCW  = 24;
  localparam int NN    = N * N;
  localparam int EB    = DW / 8;
  localparam int RES   = NN * ACCW / 8;
  localparam int NCUBE = N * N * N;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, acc_mode, clear;
  logic [7:0] data_in, data_out;
  logic       out_valid, result_ready, busy;

  int     checks = 0;
  int     failures = 0;
  int     ma [NN];
  int     mb [NN];
  longint macc [NN];
  int     exp_q [$];

  always #5 clk = ~clk;

  tensor_mmu_stream #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .acc_mode     (acc_mode),
    .clear        (clear),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] elem_byte(input int v, input int bb);
    return 8'((v >>> (8 * bb)) & 255);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    tick();
  endtask

  task automatic load_a_from(input int start);
    for (int x = start; x < NN * EB; x++) send_byte(elem_byte(ma[x / EB], x % EB));
  endtask

  task automatic model_compute(input int mode);
    longint mask = (longint'(1) << ACCW) - 1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        longint s = 0;
        for (int q = 0; q < N; q++) s += longint'(ma[r*N+q]) * longint'(mb[q*N+c]);
        macc[r*N+c] = ((mode != 0 ? macc[r*N+c] : 0) + s) & mask;
      end
    for (int e = 0; e < NN; e++)
      for (int bb = 0; bb < ACCW / 8; bb++) exp_q.push_back(int'((macc[e] >> (8 * bb)) & 255));
  endtask

  task automatic model_clear();
    for (int e = 0; e < NN; e++) macc[e] = 0;
    exp_q.delete();
  endtask

  // abort != 0: assert clear on the 4th COMPUTE cycle instead of waiting for DONE.
  task automatic load_b_compute(input int mode, input int abort);
    int cycles;
    acc_mode = mode[0];
    for (int x = 0; x < NN * EB - 1; x++) send_byte(elem_byte(mb[x / EB], x % EB));
    data_in = elem_byte(mb[NN-1], EB - 1);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    model_compute(mode);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL e0_busy got=%b want=1", busy); end
    if (abort != 0) begin
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b want=0", busy); end
      checks++;
      if (result_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%b want=0", result_ready); end
      model_clear();
      tick();
    end else begin
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin tick(); cycles++; end
      checks++;
      if (cycles != NCUBE) begin failures++; $display("FAIL latency got=%0d want=%0d", cycles, NCUBE); end
      checks++;
      if (result_ready !== 1'b1) begin failures++; $display("FAIL ready_after_compute got=%b want=1", result_ready); end
    end
  endtask

  task automatic read_bytes(input int cnt, input bit full);
    int exp_b;
    for (int n = 0; n < cnt; n++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty got=%0d want=>0", exp_q.size());
        exp_b = 0;
      end else exp_b = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rd_valid byte=%0d got=%b want=1", n, out_valid); end
      checks++;
      if (data_out !== 8'(exp_b)) begin failures++; $display("FAIL rd_data byte=%0d got=%02h want=%02h", n, data_out, 8'(exp_b)); end
      checks++;
      if (result_ready !== ((full && n == cnt - 1) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL rd_ready byte=%0d got=%b", n, result_ready);
      end
      rd_en = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_pulse byte=%0d got=%b want=0", n, out_valid); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; acc_mode = 1'b0; clear = 1'b0; data_in = 8'h00;
    model_clear();
    tick(); tick();
    checks++; if (data_out !== 8'h00)     begin failures++; $display("FAIL reset_data got=%02h want=00", data_out); end
    checks++; if (out_valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (result_ready !== 1'b0)  begin failures++; $display("FAIL reset_ready got=%b want=0", result_ready); end
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_overwrite();
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    load_a_from(0);
    load_b_compute(0, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_accumulate();
    load_a_from(0);
    load_b_compute(1, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_negative();
    ma = '{-128, -128, -128, -128};
    mb = '{-128, -128, -128, -128};
    load_a_from(0);
    load_b_compute(0, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_clear_mid_compute();
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    load_a_from(0);
    load_b_compute(0, 1);
    load_a_from(0);
    load_b_compute(1, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_strobe_levels();
    for (int t = 0; t < 3; t++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_in_load got=%b want=0", out_valid); end
      rd_en = 1'b0;
      tick();
    end
    ma = '{-3, 5, 7, -2};
    mb = '{4, -6, 9, 1};
    data_in = elem_byte(ma[0], 0);
    wr_en   = 1'b1;
    repeat (10) tick();
    wr_en   = 1'b0;
    tick();
    load_a_from(1);
    load_b_compute(0, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_back_to_back_abandon();
    ma = '{2, 0, -1, 3};
    mb = '{1, 1, 1, 1};
    load_a_from(0);
    load_b_compute(1, 0);
    read_bytes(3, 1'b0);
    exp_q.delete();
    ma = '{10, -20, 30, -40};
    mb = '{-1, 2, 3, 4};
    data_in = elem_byte(ma[0], 0);
    wr_en   = 1'b1;
    tick();
    checks++;
    if (result_ready !== 1'b0) begin failures++; $display("FAIL abandon_ready got=%b want=0", result_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abandon_valid got=%b want=0", out_valid); end
    wr_en = 1'b0;
    tick();
    load_a_from(1);
    load_b_compute(0, 0);
    read_bytes(RES, 1'b1);
  endtask

  task automatic test_read_with_clear();
    ma = '{7, -8, 9, 10};
    mb = '{3, 3, -3, 2};
    load_a_from(0);
    load_b_compute(1, 0);
    rd_en = 1'b1;
    clear = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_clear_valid got=%b want=0", out_valid); end
    checks++;
    if (result_ready !== 1'b0) begin failures++; $display("FAIL rd_clear_ready got=%b want=0", result_ready); end
    rd_en = 1'b0;
    clear = 1'b0;
    model_clear();
    tick();
    load_a_from(0);
    load_b_compute(1, 0);
    read_bytes(RES, 1'b1);
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accumulate();
    test_negative();
    test_clear_mid_compute();
    test_strobe_levels();
    test_back_to_back_abandon();
    test_read_with_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
